branch_predictor_table: RTL and testbench

Parametrised successor to the single-FSM branch predictor. It holds a direct-mapped table of 2^INDEX_BITS tagged saturating counters, indexed by branch PC, so each branch is predicted independently. The decode stage looks up the table combinationally; the MEM stage trains it with the resolved outcome. It also keeps saturating update and mispredict statistics counters for bring-up and benchmarking.

---
 rtl/branch_predictor_table_if.sv | 57 +++++
 rtl/branch_predictor_table.sv | 144 ++++++++++++++
 tb/tb_branch_predictor_table.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_table_if.sv
// Purpose: bundles the decode lookup, MEM training and statistics signals of the branch predictor table.
// Latency: none of its own; lookup outputs are combinational, statistics are registered in the predictor.
// Backpressure: none; the predictor accepts a lookup and an update every cycle.
interface branch_predictor_table_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int STAT_WIDTH = 32
);
    // Decode-stage lookup
    logic                  branch_decode_sig;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] branch_addr;
    logic                  prediction;

    // MEM-stage training
    logic                  branch_mem_sig;
    logic [ADDR_WIDTH-1:0] update_pc;
    logic                  actual_branch_decision;
    logic                  predicted_mem;

    // Statistics
    logic                  stat_clr;
    logic [STAT_WIDTH-1:0] update_count;
    logic [STAT_WIDTH-1:0] mispredict_count;

    // Pipeline side: drives lookups and updates, consumes predictions and statistics.
    modport master (
        output branch_decode_sig,
        output in_addr,
        output offset,
        input  branch_addr,
        input  prediction,
        output branch_mem_sig,
        output update_pc,
        output actual_branch_decision,
        output predicted_mem,
        output stat_clr,
        input  update_count,
        input  mispredict_count
    );

    // Predictor side.
    modport slave (
        input  branch_decode_sig,
        input  in_addr,
        input  offset,
        output branch_addr,
        output prediction,
        input  branch_mem_sig,
        input  update_pc,
        input  actual_branch_decision,
        input  predicted_mem,
        input  stat_clr,
        output update_count,
        output mispredict_count
    );
endinterface

// File: rtl/branch_predictor_table.sv
// Purpose: direct-mapped table of tagged saturating counters predicting conditional branches per PC.
// Latency: lookup is combinational (0 cycles); a training update is visible to lookups one cycle later.
// Backpressure: none; one lookup and one update are accepted every cycle, never stalls.
module branch_predictor_table #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter int STAT_WIDTH = 32
) (
    input logic                     clk,
    input logic                     rst_n,
    branch_predictor_table_if.slave bus
);

    localparam int NUM_ENTRIES = 1 << INDEX_BITS;
    localparam int IDX_LSB     = 2;
    localparam int TAG_LSB     = INDEX_BITS + 2;

    // Counter encodings: MSB is the taken/not-taken decision, the rest is confidence.
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = {1'b1, {(CTR_BITS-1){1'b0}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX     = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_MIN     = '0;

    typedef logic [INDEX_BITS-1:0] idx_t;
    typedef logic [TAG_BITS-1:0]   tag_t;
    typedef logic [CTR_BITS-1:0]   ctr_t;

    typedef struct packed {
        logic vld;
        tag_t tag;
        ctr_t ctr;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{vld: 1'b0, tag: '0, ctr: CTR_WEAK_NT};

    // Reject parameter sets whose index/tag fields do not fit in the PC.
    generate
        if (TAG_BITS < 1 || CTR_BITS < 2 || INDEX_BITS < 1 ||
            INDEX_BITS + TAG_BITS + 2 > ADDR_WIDTH) begin : g_bad_params
            $error("branch_predictor_table: illegal INDEX_BITS/TAG_BITS/CTR_BITS for ADDR_WIDTH");
        end
    endgenerate

    entry_t                tbl [NUM_ENTRIES];

    idx_t                  lu_idx;
    tag_t                  lu_tag;
    entry_t                lu_ent;
    logic                  lu_hit;

    idx_t                  upd_idx;
    tag_t                  upd_tag;
    entry_t                upd_ent;
    logic                  upd_hit;
    entry_t                upd_ent_nxt;

    logic                  mispredict;
    logic [STAT_WIDTH-1:0] upd_cnt_q;
    logic [STAT_WIDTH-1:0] mis_cnt_q;

    // Low byte-offset bits and PC bits above the tag are deliberately ignored (aliasing is accepted).
    logic                  unused_pc_bits;
    assign unused_pc_bits = ^{bus.in_addr, bus.update_pc};

    // ------------------------------------------------------------------
    // Decode-side lookup: reads the pre-edge table, no bypass from a
    // same-cycle update.
    // ------------------------------------------------------------------
    assign lu_idx = bus.in_addr[TAG_LSB-1:IDX_LSB];
    assign lu_tag = bus.in_addr[TAG_LSB+TAG_BITS-1:TAG_LSB];
    assign lu_ent = tbl[lu_idx];
    assign lu_hit = lu_ent.vld && (lu_ent.tag == lu_tag);

    assign bus.branch_addr = bus.in_addr + bus.offset;
    assign bus.prediction  = bus.branch_decode_sig & lu_hit & lu_ent.ctr[CTR_BITS-1];

    // ------------------------------------------------------------------
    // MEM-side training
    // ------------------------------------------------------------------
    assign upd_idx = bus.update_pc[TAG_LSB-1:IDX_LSB];
    assign upd_tag = bus.update_pc[TAG_LSB+TAG_BITS-1:TAG_LSB];
    assign upd_ent = tbl[upd_idx];
    assign upd_hit = upd_ent.vld && (upd_ent.tag == upd_tag);

    // Next entry value: saturating step on a hit, fresh weak allocation on a miss.
    always_comb begin
        upd_ent_nxt = upd_ent;
        if (upd_hit) begin
            if (bus.actual_branch_decision) begin
                if (upd_ent.ctr != CTR_MAX) begin
                    upd_ent_nxt.ctr = upd_ent.ctr + CTR_BITS'(1);
                end
            end else begin
                if (upd_ent.ctr != CTR_MIN) begin
                    upd_ent_nxt.ctr = upd_ent.ctr - CTR_BITS'(1);
                end
            end
        end else begin
            upd_ent_nxt.vld = 1'b1;
            upd_ent_nxt.tag = upd_tag;
            upd_ent_nxt.ctr = bus.actual_branch_decision ? CTR_WEAK_T : CTR_WEAK_NT;
        end
    end

    // Table storage: cleared by reset, one entry written per update strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl[i] <= ENTRY_RESET;
            end
        end else if (bus.branch_mem_sig) begin
            tbl[upd_idx] <= upd_ent_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    assign mispredict = bus.predicted_mem ^ bus.actual_branch_decision;

    // Saturating update/mispredict counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else if (bus.stat_clr) begin
            upd_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else if (bus.branch_mem_sig) begin
            if (!(&upd_cnt_q)) begin
                upd_cnt_q <= upd_cnt_q + STAT_WIDTH'(1);
            end
            if (mispredict && !(&mis_cnt_q)) begin
                mis_cnt_q <= mis_cnt_q + STAT_WIDTH'(1);
            end
        end
    end

    assign bus.update_count     = upd_cnt_q;
    assign bus.mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor_table.sv
// Purpose: randomized and directed check of branch_predictor_table against a behavioural model.
// Latency: expectations are pushed at drive time and popped by the monitor on the falling edge.
// Backpressure: none; one expectation per cycle.
module tb_branch_predictor_table;

    localparam int AW = 32;
    localparam int IB = 6;
    localparam int TB = 8;
    localparam int CB = 2;
    localparam int SW = 4;          // narrow statistics so saturation is reachable
    localparam int NE = 1 << IB;
    localparam int WT = 1 << (CB - 1);
    localparam int WNT = WT - 1;
    localparam int CMAX = (1 << CB) - 1;
    localparam int SMAX = (1 << SW) - 1;

    logic clk;
    logic rst_n;

    branch_predictor_table_if #(.ADDR_WIDTH(AW), .STAT_WIDTH(SW)) bus ();

    branch_predictor_table #(
        .ADDR_WIDTH(AW), .INDEX_BITS(IB), .TAG_BITS(TB), .CTR_BITS(CB), .STAT_WIDTH(SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_vld [NE];
    int unsigned m_tag [NE];
    int          m_ctr [NE];
    int          m_upd;
    int          m_mis;

    function automatic int unsigned pidx(input logic [31:0] pc);
        return (pc >> 2) % NE;
    endfunction

    function automatic int unsigned ptag(input logic [31:0] pc);
        return (pc >> (IB + 2)) % (1 << TB);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NE; i++) begin
            m_vld[i] = 1'b0;
            m_tag[i] = 0;
            m_ctr[i] = WNT;
        end
        m_upd = 0;
        m_mis = 0;
    endfunction

    function automatic bit model_pred(input logic [31:0] pc);
        int unsigned i;
        i = pidx(pc);
        return m_vld[i] && (m_tag[i] == ptag(pc)) && (m_ctr[i] >= WT);
    endfunction

    function automatic void model_train(input logic [31:0] pc, input bit taken);
        int unsigned i;
        i = pidx(pc);
        if (m_vld[i] && m_tag[i] == ptag(pc)) begin
            if (taken) m_ctr[i] = (m_ctr[i] + 1 > CMAX) ? CMAX : m_ctr[i] + 1;
            else       m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end else begin
            m_vld[i] = 1'b1;
            m_tag[i] = ptag(pc);
            m_ctr[i] = taken ? WT : WNT;
        end
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] addr;
        bit          pred;
        int          upd;
        int          mis;
    } exp_t;

    exp_t sb_q [$];
    int   tests_run;
    int   tests_failed;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    // Monitor: outputs are always presented, so one expectation is consumed per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("branch_addr", bus.branch_addr, e.addr);
                check("prediction", {31'b0, bus.prediction}, {31'b0, e.pred});
                check("update_count", {{(32-SW){1'b0}}, bus.update_count}, e.upd);
                check("mispredict_count", {{(32-SW){1'b0}}, bus.mispredict_count}, e.mis);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit rst, input bit dec, input logic [31:0] ia, input logic [31:0] off,
                         input bit mem, input logic [31:0] upc, input bit act, input bit pm,
                         input bit clr);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n                      = rst;
        bus.branch_decode_sig      = dec;
        bus.in_addr                = ia;
        bus.offset                 = off;
        bus.branch_mem_sig         = mem;
        bus.update_pc              = upc;
        bus.actual_branch_decision = act;
        bus.predicted_mem          = pm;
        bus.stat_clr               = clr;
        if (!rst) model_reset();
        e.addr = ia + off;
        e.pred = dec && model_pred(ia);
        e.upd  = m_upd;
        e.mis  = m_mis;
        sb_q.push_back(e);
        if (rst) begin
            if (clr) begin
                m_upd = 0;
                m_mis = 0;
            end else if (mem) begin
                if (m_upd < SMAX) m_upd++;
                if (pm != act && m_mis < SMAX) m_mis++;
            end
            if (mem) model_train(upc, act);
        end
    endtask

    // Lookup and train the same PC in one cycle; carried prediction is the model's own.
    task automatic upd(input logic [31:0] pc, input bit taken);
        drive(1, 1, pc, 32'h10, 1, pc, taken, model_pred(pc), 0);
    endtask

    task automatic look(input logic [31:0] pc);
        drive(1, 1, pc, 32'h10, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic pulse_reset();
        drive(0, 1, 32'h40, 32'h0, 1, 32'h40, 1, 0, 0);
        look(32'h40);
    endtask

    initial begin
        logic [31:0] pc_a;
        logic [31:0] pc_b;
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.branch_decode_sig      = 1'b0;
        bus.in_addr                = '0;
        bus.offset                 = '0;
        bus.branch_mem_sig         = 1'b0;
        bus.update_pc              = '0;
        bus.actual_branch_decision = 1'b0;
        bus.predicted_mem          = 1'b0;
        bus.stat_clr               = 1'b0;
        model_reset();

        // Reset then lookup
        drive(0, 1, 32'h100, 32'h20, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h100, 32'h20, 0, 0, 0, 0, 0);

        // Training hysteresis on 0x40
        upd(32'h40, 1); upd(32'h40, 1); upd(32'h40, 0); upd(32'h40, 0); look(32'h40);

        // Saturation both ways
        pulse_reset();
        repeat (5) upd(32'h40, 1);
        upd(32'h40, 0); look(32'h40);
        repeat (6) upd(32'h40, 0);
        upd(32'h40, 1); look(32'h40);

        // Aliasing on index 16
        pulse_reset();
        repeat (3) upd(32'h40, 1);
        look(32'h140);
        upd(32'h140, 0);
        look(32'h40); look(32'h140);

        // Same-cycle lookup and update
        upd(32'h80, 0);
        drive(1, 1, 32'h80, 32'h4, 1, 32'h80, 1, 0, 0);
        look(32'h80);

        // Statistics
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 1, 32'h200, 1, 1, 0);
        drive(1, 0, 0, 0, 1, 32'h204, 1, 0, 0);
        drive(1, 0, 0, 0, 1, 32'h208, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 32'h20c, 1, 0, 1);
        look(32'h200);

        // Statistic saturation
        repeat (20) drive(1, 0, 0, 0, 1, 32'h300, 1, 0, 0);
        look(32'h300);

        // Reset mid-training
        repeat (3) upd(32'h40, 1);
        drive(0, 1, 32'h40, 32'h0, 1, 32'h40, 1, 1, 0);
        look(32'h40); look(32'h80);

        // Randomized traffic over a small PC pool with random upper bits
        for (int n = 0; n < 800; n++) begin
            pc_a = ($urandom & 32'hFFFF_0000) | ($urandom_range(0, 3) << 8) |
                   ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            pc_b = ($urandom & 32'hFFFF_0000) | ($urandom_range(0, 3) << 8) |
                   ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) pc_b = pc_a;
            drive(($urandom_range(0, 199) != 0), $urandom_range(0, 3) != 0, pc_a, $urandom,
                  $urandom_range(0, 2) != 0, pc_b, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
        end

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
